// File: rtl/comm_wr_adr.sv
// comm_wr_adr: write-side address generator for one frame buffer.
// Emits a fixed-width WR pulse per word strobe and raises strob when the frame is full.
module comm_wr_adr #(
    parameter int N_WORDS = 18,
    parameter int WR_LEN  = 4,
    parameter int AW      = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wrStb,
    input  logic          i_frameStart,
    input  logic          i_rstWr,
    output logic          o_WR,
    output logic [AW-1:0] o_WrAdr,
    output logic          o_strob,
    output logic          o_ovf
);
    typedef enum logic [1:0] {FILL, WRITE, ADV, FULL} state_t;

    state_t        r_state, w_state;
    logic [2:0]    r_sync;
    logic [3:0]    r_cnt, w_cnt;
    logic          w_wr, w_strob, w_ovf, w_edge;
    logic [AW-1:0] w_adr;

    assign w_edge = r_sync[2:1] == 2'b01;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= FILL;
            r_sync  <= '0;
            r_cnt   <= '0;
            o_WR    <= 1'b0;
            o_WrAdr <= '0;
            o_strob <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_sync  <= {r_sync[1:0], i_wrStb};
            r_cnt   <= w_cnt;
            o_WR    <= w_wr;
            o_WrAdr <= w_adr;
            o_strob <= w_strob;
            o_ovf   <= w_ovf;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_wr    = o_WR;
        w_adr   = o_WrAdr;
        w_strob = o_strob;
        w_ovf   = o_ovf;
        if (i_rstWr) begin
            // reader reset wins everywhere; only a consumed frame clears the overflow
            w_state = FILL;
            w_wr    = 1'b0;
            w_adr   = '0;
            w_strob = 1'b0;
            w_ovf   = (r_state == FULL) ? 1'b0 : o_ovf;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_edge) begin
                        w_wr    = 1'b1;
                        w_cnt   = 4'(WR_LEN);
                        w_state = WRITE;
                    end else if (i_frameStart) begin
                        w_adr = '0;
                    end
                end
                WRITE: begin
                    w_ovf   = o_ovf | w_edge;
                    w_wr    = r_cnt != 4'd1;
                    w_cnt   = r_cnt - 4'd1;
                    w_state = (r_cnt == 4'd1) ? ADV : WRITE;
                end
                ADV: begin
                    w_ovf   = o_ovf | w_edge;
                    w_adr   = o_WrAdr + AW'(1);
                    w_strob = o_WrAdr == AW'(N_WORDS - 1);
                    w_state = (o_WrAdr == AW'(N_WORDS - 1)) ? FULL : FILL;
                end
                FULL: w_ovf = o_ovf | w_edge;
            endcase
        end
    end
endmodule

// File: tb/tb_comm_wr_adr.sv
// tb_comm_wr_adr: vector table, directed corner sequences and random stimulus
// checked against a time-window model of the write side.
module tb_comm_wr_adr;
    localparam int N  = 18;
    localparam int L  = 4;
    localparam int AW = 5;

    logic          clk = 1'b0, rst_n = 1'b0, wr_stb = 1'b0, fs = 1'b0, rw = 1'b0;
    logic          wr, strob, ovf;
    logic [AW-1:0] adr;

    always #5 clk = ~clk;

    comm_wr_adr #(.N_WORDS(N), .WR_LEN(L), .AW(AW)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_wrStb(wr_stb), .i_frameStart(fs), .i_rstWr(rw),
        .o_WR(wr), .o_WrAdr(adr), .o_strob(strob), .o_ovf(ovf)
    );

    int errors = 0, checks = 0;

    // model: cycle count, start cycle of the accepted write, words stored, flags
    int cyc, ws, m_n;
    bit m_full, m_ovf;
    bit hist[$];

    function automatic void m_reset();
        cyc = 0; ws = -1000; m_n = 0; m_full = 0; m_ovf = 0;
        hist = '{0, 0, 0};
    endfunction

    function automatic void m_clock(bit s, bit f, bit r);
        bit e, busy;
        cyc++;
        e    = hist[1] && !hist[2];
        busy = cyc > ws && cyc <= ws + L + 1;
        if (r) begin
            if (m_full) begin m_full = 0; m_ovf = 0; end
            ws = -1000; m_n = 0;
        end else if (m_full) begin
            if (e) m_ovf = 1;
        end else if (busy) begin
            if (e) m_ovf = 1;
            if (cyc == ws + L + 1) begin
                m_n++;
                if (m_n == N) m_full = 1;
            end
        end else if (e) ws = cyc;
        else if (f) m_n = 0;
        hist.push_front(s);
        void'(hist.pop_back());
    endfunction

    function automatic bit m_wr();
        return cyc >= ws && cyc < ws + L;
    endfunction

    task automatic chk(string nm, logic [AW+2:0] got, logic [AW+2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {wr,adr,strob,ovf}=%h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_model(string nm);
        chk(nm, {wr, adr, strob, ovf}, {m_wr(), AW'(m_n), m_full, m_ovf});
    endtask

    task automatic step(bit s, bit f, bit r);
        @(negedge clk);
        wr_stb = s; fs = f; rw = r;
        @(posedge clk);
        m_clock(s, f, r);
        #1;
    endtask

    task automatic mstep(string nm, bit s, bit f, bit r);
        step(s, f, r);
        chk_model(nm);
    endtask

    task automatic word(int hi, int lo, output bit saw_wr);
        saw_wr = 0;
        for (int i = 0; i < hi + lo; i++) begin
            mstep("word", i < hi, 0, 0);
            saw_wr |= wr;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; wr_stb = 0; fs = 0; rw = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        m_reset();
    endtask

    typedef struct {
        bit s, f, r;
        bit ewr;
        int eadr;
        bit est, eov;
    } vec_t;

    vec_t tbl[20];
    bit   saw;

    initial begin
        tbl = '{
            '{1,0,0, 0,0,0,0}, '{1,0,0, 0,0,0,0}, '{1,0,0, 1,0,0,0}, '{0,0,0, 1,0,0,0},
            '{0,0,0, 1,0,0,0}, '{0,0,0, 1,0,0,0}, '{0,0,0, 0,0,0,0}, '{0,0,0, 0,1,0,0},
            '{0,1,0, 0,0,0,0}, '{0,0,1, 0,0,0,0}, '{1,0,0, 0,0,0,0}, '{1,0,0, 0,0,0,0},
            '{1,0,0, 1,0,0,0}, '{0,1,0, 1,0,0,0}, '{1,0,0, 1,0,0,0}, '{1,0,0, 1,0,0,0},
            '{1,0,0, 0,0,0,1}, '{0,0,0, 0,1,0,1}, '{0,0,0, 0,1,0,1}, '{0,0,1, 0,0,0,1}
        };
        m_reset();
        #2;
        chk("reset_state", {wr, adr, strob, ovf}, '0);
        do_reset();
        chk("after_reset", {wr, adr, strob, ovf}, '0);

        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].f, tbl[i].r);
            chk($sformatf("vec%0d", i), {wr, adr, strob, ovf},
                {tbl[i].ewr, AW'(tbl[i].eadr), tbl[i].est, tbl[i].eov});
        end

        // asynchronous reset while WR is high
        do_reset();
        for (int i = 0; i < 4; i++) mstep("pre_rst", 1, 0, 0);
        chk("wr_high_before_rst", {wr, adr, strob, ovf}, {1'b1, AW'(0), 2'b00});
        rst_n = 0;
        #2;
        chk("async_rst", {wr, adr, strob, ovf}, '0);
        @(negedge clk);
        wr_stb = 0;
        rst_n = 1;
        m_reset();
        word(6, 6, saw);
        chk("rst_next_word", {saw, adr}, {1'b1, AW'(1)});

        // full frame, then an overflowing word, then the reader handshake
        do_reset();
        for (int k = 0; k < N; k++) word(6, 6, saw);
        chk("frame_full", {wr, adr, strob, ovf}, {1'b0, AW'(N), 2'b10});
        word(6, 6, saw);
        chk("word19", {saw, adr, strob, ovf}, {1'b0, AW'(N), 2'b11});
        mstep("rstwr_full", 0, 0, 1);
        chk("rstwr_clears", {wr, adr, strob, ovf}, '0);
        word(6, 6, saw);
        chk("after_frame", {saw, adr}, {1'b1, AW'(1)});

        // frame resync after five words
        mstep("clr", 0, 0, 1);
        for (int k = 0; k < 5; k++) word(6, 6, saw);
        chk("five_words", adr, AW'(5));
        mstep("fs", 0, 1, 0);
        chk("fs_resync", adr, AW'(0));
        for (int k = 0; k < N - 1; k++) word(6, 6, saw);
        chk("strob_not_yet", {adr, strob}, {AW'(N - 1), 1'b0});
        word(6, 6, saw);
        chk("strob_after_18", {adr, strob}, {AW'(N), 1'b1});
        mstep("clr2", 0, 0, 1);

        // reader abort in the second WR cycle at address 7
        for (int k = 0; k < 7; k++) word(6, 6, saw);
        for (int i = 0; i < 3; i++) mstep("abort_pre", 1, 0, 0);
        mstep("abort_wr2", 1, 0, 0);
        chk("wr_2nd_cycle", {wr, adr}, {1'b1, AW'(7)});
        mstep("abort", 0, 0, 1);
        chk("abort_result", {wr, adr, strob}, {1'b0, AW'(0), 1'b0});

        // strobe re-rising inside the write window
        do_reset();
        for (int i = 0; i < 3; i++) mstep("fast_a", 1, 0, 0);
        mstep("fast_b", 0, 0, 0);
        for (int i = 0; i < 4; i++) mstep("fast_c", 1, 0, 0);
        for (int i = 0; i < 8; i++) mstep("fast_d", 0, 0, 0);
        chk("lost_word", {wr, adr, strob, ovf}, {1'b0, AW'(1), 2'b01});

        // random traffic
        do_reset();
        begin
            bit s = 0;
            int hold = 0;
            for (int i = 0; i < 3000; i++) begin
                bit f, r;
                if (hold == 0) begin s = ~s; hold = $urandom_range(1, 8); end
                hold--;
                f = $urandom_range(0, 49) == 0;
                r = m_full ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
                mstep("random", s, f, r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
